mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shared-memory arbiter and sequencer for the core.
- Gives one single-port memory/bus slave to two requesters: instruction fetch (IF) and execute-stage load/store (LS).
- Runs one transaction at a time, returns the read data and an ack pulse to the granted requester, and raises a hold flag while a load/store is outstanding.
- Drops stale fetch responses after a jump, and bounds every transaction with a timeout.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles mem_req_o stays high without mem_ack_i before the transaction is aborted. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held high until if_ack_o
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetch data; valid while if_ack_o=1
- if_ack_o  out  1  one-cycle fetch completion pulse
- ls_req_i  in  1  load/store request; held high until ls_ack_o
- ls_we_i  in  1  1=store, 0=load
- ls_addr_i  in  32  load/store address
- ls_wdata_i  in  32  store data
- ls_wmask_i  in  4  byte write mask
- ls_rdata_o  out  32  load data; valid while ls_ack_o=1
- ls_ack_o  out  1  one-cycle load/store completion pulse
- jump_en_i  in  1  pipeline flush from ctrl (jump taken)
- mem_req_o  out  1  slave request; held until mem_ack_i or timeout
- mem_we_o  out  1  slave write enable
- mem_addr_o  out  32  slave address
- mem_wdata_o  out  32  slave write data
- mem_wmask_o  out  4  slave write mask
- mem_rdata_i  in  32  slave read data; valid with mem_ack_i
- mem_ack_i  in  1  slave completion, one cycle
- hold_flag_o  out  1  pipeline stall request to ctrl
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - state=IDLE; timeout counter and flush_pend cleared.
  - All outputs 0, including an in-flight mem_req_o.
- States: IDLE, BUSY_IF, BUSY_LS, DONE.
- IDLE:
  - ls_req_i=1: register ls_we/addr/wdata/wmask onto mem_*, set mem_req_o=1 on the next edge, go to BUSY_LS.
  - Otherwise, if_req_i=1: register if_addr_i, mem_we_o=0, mem_wmask_o=0, go to BUSY_IF.
  - LS has fixed priority when both requests are high.
  - Grant latency is 1 cycle (request sampled in IDLE, mem_req_o high the following cycle).
- BUSY_IF / BUSY_LS:
  - mem_* outputs stay stable while mem_req_o=1.
  - The counter increments each cycle.
  - On mem_ack_i: capture mem_rdata_i into the granted *_rdata_o, drop mem_req_o, go to DONE.
- DONE (exactly 1 cycle):
  - Assert the granted *_ack_o for this cycle only, then return to IDLE. No new grant in this cycle.
  - Requesters must drop or replace their request during this cycle; IDLE samples fresh requests on the following cycle.
  - Minimum gap between transactions: 1 cycle.
  - Ack-to-ack throughput with a 1-cycle slave: one transaction every 3 cycles.
- Flush handling:
  - jump_en_i=1 while in BUSY_IF sets flush_pend. The slave transaction still completes; it is never aborted.
  - In DONE with flush_pend=1: if_ack_o stays 0, if_rdata_o is held at its previous value, and flush_pend clears.
  - jump_en_i in IDLE, BUSY_LS or DONE has no effect. LS transactions are never dropped.
- Timeout (TIMEOUT_CYC≠0):
  - Counter reaches TIMEOUT_CYC with no mem_ack_i: drop mem_req_o, go to DONE.
  - In DONE: *_rdata_o=0, the granted ack fires (subject to the flush rule), bus_err_o=1 for 1 cycle.
  - mem_ack_i arriving in the same cycle as the timeout wins; this is a normal completion with no error.
  - The counter clears on entering IDLE.
- hold_flag_o = ls_req_i & ~ls_ack_o, combinational. Forced 0 during reset.
- All other outputs are registered.
- mem_ack_i in IDLE or DONE is ignored.

Test Plan:
- IF only, if_addr_i=0x100, slave acks 2 cycles after mem_req_o, rdata=0xDEADBEEF -> mem_addr_o=0x100 and mem_we_o=0 one cycle after request; if_ack_o=1 for one cycle with if_rdata_o=0xDEADBEEF, one cycle after mem_ack_i.
- if_req_i and ls_req_i (load, 0x2000) high in the same cycle, 1-cycle slave -> LS served first; ls_ack_o pulses; then the IF transaction starts on the cycle after DONE; hold_flag_o=1 until ls_ack_o.
- Store ls_addr_i=0x3004, ls_wdata_i=0x12345678, ls_wmask_i=4'b0011 -> mem_we_o=1 and mem_wmask_o=0011, stable until mem_ack_i; then ls_ack_o pulse.
- Fetch outstanding, jump_en_i pulsed, slave acks 3 cycles later -> no if_ack_o; next IDLE grants a new fetch normally.
- TIMEOUT_CYC=4, slave never acks -> mem_req_o high exactly 4 cycles; ack pulse with rdata=0 and bus_err_o=1 in DONE. Repeat with mem_ack_i on the timeout cycle -> normal completion, bus_err_o=0.
- Assert rst=0 mid-BUSY_LS -> mem_req_o, hold_flag_o and all acks go 0 immediately; after release the FSM is in IDLE and the re-presented request completes correctly.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch / load-store arbiter and sequencer for one single-port memory slave
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_wmask_i,
    output logic [31:0] ls_rdata_o,
    output logic        ls_ack_o,
    input  logic        jump_en_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        hold_flag_o,
    output logic        bus_err_o
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DONE} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic flush_pend, busy, grant, timeout, finish, drop;
    assign hold_flag_o = rst && ls_req_i && !ls_ack_o;
    // next state and transaction events; a jump seen in the completing cycle also drops the fetch
    always_comb begin
        busy = (state == BUSY_IF) || (state == BUSY_LS);
        grant = (state == IDLE) && (ls_req_i || if_req_i);
        timeout = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
        finish = busy && (mem_ack_i || timeout);
        drop = flush_pend || jump_en_i;
        state_nxt = state;
        if (grant) state_nxt = ls_req_i ? BUSY_LS : BUSY_IF;
        else if (finish) state_nxt = DONE;
        else if (state == DONE) state_nxt = IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end
    // registered bus signals, responses, timeout counter and flush tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            flush_pend <= 1'b0;
            mem_req_o <= 1'b0;
            mem_we_o <= 1'b0;
            mem_addr_o <= '0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            if_ack_o <= 1'b0;
            ls_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            if_rdata_o <= '0;
            ls_rdata_o <= '0;
        end else begin
            cnt <= busy ? cnt + 1'b1 : '0;
            flush_pend <= (state == BUSY_IF && jump_en_i) || (flush_pend && state != DONE);
            if (grant) begin
                mem_req_o <= 1'b1;
                mem_we_o <= ls_req_i && ls_we_i;
                mem_addr_o <= ls_req_i ? ls_addr_i : if_addr_i;
                mem_wdata_o <= ls_req_i ? ls_wdata_i : '0;
                mem_wmask_o <= ls_req_i ? ls_wmask_i : '0;
            end else if (finish) begin
                mem_req_o <= 1'b0;
            end
            if_ack_o <= finish && state == BUSY_IF && !drop;
            ls_ack_o <= finish && state == BUSY_LS;
            bus_err_o <= finish && !mem_ack_i;
            if (finish && state == BUSY_IF && !drop) if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            if (finish && state == BUSY_LS) ls_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        ls_req_i = 1'b0;
    logic        ls_we_i = 1'b0;
    logic [31:0] ls_addr_i = '0;
    logic [31:0] ls_wdata_i = '0;
    logic [3:0]  ls_wmask_i = '0;
    logic [31:0] ls_rdata_o;
    logic        ls_ack_o;
    logic        jump_en_i = 1'b0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_rdata_i = 32'hFFFF_FFFF;
    logic        mem_ack_i = 1'b0;
    logic        hold_flag_o;
    logic        bus_err_o;

    mem_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
        .ls_wmask_i(ls_wmask_i), .ls_rdata_o(ls_rdata_o), .ls_ack_o(ls_ack_o),
        .jump_en_i(jump_en_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .hold_flag_o(hold_flag_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_ls;
        logic        flushed;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_if_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input logic is_ls, input logic flushed, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_ls = is_ls;
        e.flushed = flushed;
        e.rdata = rdata;
        e.err = err;
        sb.push_back(e);
    endtask

    // slave answers after lat further cycles; returns in the DONE cycle
    task automatic serve(input int lat, input logic [31:0] data);
        repeat (lat) tick();
        mem_ack_i = 1'b1;
        mem_rdata_i = data;
        tick();
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'hFFFF_FFFF;
    endtask

    // called in the DONE cycle: compare the response against the oldest expectation
    task automatic pop_check(input string tag);
        exp_t e;
        logic [31:0] want;
        e = sb.pop_front();
        want = (e.is_ls || !e.flushed) ? e.rdata : last_if_rdata;
        chk({tag, " ls_ack"}, 32'(ls_ack_o), 32'(e.is_ls));
        chk({tag, " if_ack"}, 32'(if_ack_o), 32'(!e.is_ls && !e.flushed));
        chk({tag, " rdata"}, e.is_ls ? ls_rdata_o : if_rdata_o, want);
        chk({tag, " bus_err"}, 32'(bus_err_o), 32'(e.err));
        chk({tag, " req_drop"}, 32'(mem_req_o), 32'd0);
        if (!e.is_ls && !e.flushed) last_if_rdata = e.rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ls_req_i = 1'b1;
        repeat (2) tick();
        chk("rst mem_req", 32'(mem_req_o), 0);
        chk("rst hold", 32'(hold_flag_o), 0);
        chk("rst if_ack", 32'(if_ack_o), 0);
        chk("rst ls_ack", 32'(ls_ack_o), 0);
        chk("rst bus_err", 32'(bus_err_o), 0);
        chk("rst addr", mem_addr_o, 0);
        ls_req_i = 1'b0;
        rst = 1'b1;
        tick();
        // fetch only, slave answers two cycles after the request
        if_addr_i = 32'h100;
        if_req_i = 1'b1;
        expect_txn(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("t1 req", 32'(mem_req_o), 1);
        chk("t1 addr", mem_addr_o, 32'h100);
        chk("t1 we", 32'(mem_we_o), 0);
        chk("t1 early ack", 32'(if_ack_o), 0);
        tick();
        tick();
        chk("t1 req held", 32'(mem_req_o), 1);
        serve(0, 32'hDEAD_BEEF);
        pop_check("t1");
        if_req_i = 1'b0;
        tick();
        chk("t1 ack pulse", 32'(if_ack_o), 0);
        // simultaneous requests: load wins, fetch follows after DONE
        if_addr_i = 32'h104;
        if_req_i = 1'b1;
        ls_addr_i = 32'h2000;
        ls_we_i = 1'b0;
        ls_wmask_i = 4'b0000;
        ls_req_i = 1'b1;
        #1;
        chk("t2 hold idle", 32'(hold_flag_o), 1);
        expect_txn(1'b1, 1'b0, 32'h1111_2222, 1'b0);
        tick();
        chk("t2 ls addr", mem_addr_o, 32'h2000);
        chk("t2 ls we", 32'(mem_we_o), 0);
        chk("t2 hold busy", 32'(hold_flag_o), 1);
        serve(0, 32'h1111_2222);
        pop_check("t2 ls");
        chk("t2 hold done", 32'(hold_flag_o), 0);
        ls_req_i = 1'b0;
        expect_txn(1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
        tick();
        chk("t2 idle gap", 32'(mem_req_o), 0);
        tick();
        chk("t2 if req", 32'(mem_req_o), 1);
        chk("t2 if addr", mem_addr_o, 32'h104);
        serve(0, 32'h0BAD_F00D);
        pop_check("t2 if");
        if_req_i = 1'b0;
        tick();
        // store with byte mask; a jump during a store has no effect
        ls_we_i = 1'b1;
        ls_addr_i = 32'h3004;
        ls_wdata_i = 32'h1234_5678;
        ls_wmask_i = 4'b0011;
        ls_req_i = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h0000_0000, 1'b0);
        tick();
        chk("t3 we", 32'(mem_we_o), 1);
        chk("t3 mask", 32'(mem_wmask_o), 32'b0011);
        chk("t3 addr", mem_addr_o, 32'h3004);
        chk("t3 wdata", mem_wdata_o, 32'h1234_5678);
        jump_en_i = 1'b1;
        tick();
        jump_en_i = 1'b0;
        chk("t3 we held", 32'(mem_we_o), 1);
        chk("t3 mask held", 32'(mem_wmask_o), 32'b0011);
        chk("t3 wdata held", mem_wdata_o, 32'h1234_5678);
        serve(0, 32'h0000_0000);
        pop_check("t3");
        ls_req_i = 1'b0;
        ls_we_i = 1'b0;
        ls_wmask_i = 4'b0000;
        tick();
        // fetch flushed by a jump; the next fetch is served normally
        if_addr_i = 32'h200;
        if_req_i = 1'b1;
        expect_txn(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0);
        tick();
        jump_en_i = 1'b1;
        tick();
        jump_en_i = 1'b0;
        serve(1, 32'hBAD0_BAD0);
        pop_check("t4 flush");
        if_addr_i = 32'h300;
        expect_txn(1'b0, 1'b0, 32'h55AA_55AA, 1'b0);
        tick();
        tick();
        chk("t4 refetch addr", mem_addr_o, 32'h300);
        serve(0, 32'h55AA_55AA);
        pop_check("t4 refetch");
        if_req_i = 1'b0;
        tick();
        // jump arriving in the same cycle as the slave ack still drops the fetch
        if_addr_i = 32'h400;
        if_req_i = 1'b1;
        expect_txn(1'b0, 1'b1, 32'h7777_0000, 1'b0);
        tick();
        jump_en_i = 1'b1;
        serve(0, 32'h7777_0000);
        jump_en_i = 1'b0;
        pop_check("t4b flush");
        if_req_i = 1'b0;
        tick();
        // timeout: slave never answers
        ls_addr_i = 32'h4000;
        ls_req_i = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h0, 1'b1);
        for (int c = 0; c < TO; c++) begin
            tick();
            chk($sformatf("t5 req c%0d", c), 32'(mem_req_o), 1);
        end
        tick();
        pop_check("t5 timeout");
        ls_req_i = 1'b0;
        tick();
        chk("t5 err pulse", 32'(bus_err_o), 0);
        // ack on the timeout cycle wins
        ls_addr_i = 32'h4004;
        ls_req_i = 1'b1;
        expect_txn(1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
        tick();
        serve(TO - 1, 32'hCAFE_F00D);
        pop_check("t5 race");
        ls_req_i = 1'b0;
        tick();
        // reset in the middle of a load
        ls_addr_i = 32'h5000;
        ls_req_i = 1'b1;
        tick();
        tick();
        chk("t6 busy req", 32'(mem_req_o), 1);
        rst = 1'b0;
        #1;
        chk("t6 rst req", 32'(mem_req_o), 0);
        chk("t6 rst hold", 32'(hold_flag_o), 0);
        chk("t6 rst ls_ack", 32'(ls_ack_o), 0);
        chk("t6 rst if_ack", 32'(if_ack_o), 0);
        tick();
        rst = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h600D_D00D, 1'b0);
        tick();
        chk("t6 regrant req", 32'(mem_req_o), 1);
        chk("t6 regrant addr", mem_addr_o, 32'h5000);
        chk("t6 hold", 32'(hold_flag_o), 1);
        serve(1, 32'h600D_D00D);
        pop_check("t6");
        ls_req_i = 1'b0;
        tick();
        chk("t6 ack pulse", 32'(ls_ack_o), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
